// File: rtl/csr_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter_bank
// Description : RISC-V machine counter CSR bank (mcycle, minstret, mhpmcounters)
//               with mcountinhibit, csrrw/csrrs/csrrc ops and overflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter_bank #(
    parameter int NUM_COUNTERS = 4,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             csr_raddr,
    output logic [31:0]             csr_rdata,
    output logic                    csr_rd_illegal,
    input  logic [1:0]              csr_op,
    input  logic [11:0]             csr_waddr,
    input  logic [31:0]             csr_wdata,
    output logic                    csr_wr_illegal,
    input  logic [NUM_COUNTERS-1:0] evt_i,
    output logic [NUM_COUNTERS-1:0] ovf_o
);

    localparam int          HI_W         = CNT_WIDTH - 32;
    localparam logic [1:0]  OP_NONE      = 2'b00;
    localparam logic [1:0]  OP_WRITE     = 2'b01;
    localparam logic [1:0]  OP_SET       = 2'b10;
    localparam logic [1:0]  OP_CLEAR     = 2'b11;
    localparam logic [11:0] ADDR_MLO     = 12'hB00;
    localparam logic [11:0] ADDR_MHI     = 12'hB80;
    localparam logic [11:0] ADDR_ULO     = 12'hC00;
    localparam logic [11:0] ADDR_UHI     = 12'hC80;
    localparam logic [11:0] ADDR_INHIBIT = 12'h320;

    // CSR offset of counter i; offset 1 (time) is skipped.
    function automatic logic [4:0] off_f(input int i);
        if (i == 0)      return 5'd0;
        else if (i == 1) return 5'd2;
        else             return 5'(i + 1);
    endfunction

    function automatic logic [11:0] addr_f(input logic [11:0] base, input int i);
        return base | {7'd0, off_f(i)};
    endfunction

    logic [CNT_WIDTH-1:0]    cnt_q [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] inh_q, inh_d;
    logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
    logic [NUM_COUNTERS-1:0] w_en, w_wrap;
    logic [31:0]             w_inh_view, w_wold, w_wnew;
    logic                    w_wmapped, w_we;

    always_comb begin
        w_inh_view = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            w_inh_view[off_f(i)] = inh_q[i];
        end
    end

    always_comb begin
        csr_rdata      = '0;
        csr_rd_illegal = 1'b1;
        if (csr_raddr == ADDR_INHIBIT) begin
            csr_rdata      = w_inh_view;
            csr_rd_illegal = 1'b0;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (csr_raddr == addr_f(ADDR_MLO, i) || csr_raddr == addr_f(ADDR_ULO, i)) begin
                csr_rdata      = cnt_q[i][31:0];
                csr_rd_illegal = 1'b0;
            end
            if (csr_raddr == addr_f(ADDR_MHI, i) || csr_raddr == addr_f(ADDR_UHI, i)) begin
                csr_rdata      = 32'(cnt_q[i][CNT_WIDTH-1:32]);
                csr_rd_illegal = 1'b0;
            end
        end
    end

    // Only the machine-mode aliases and mcountinhibit are writable.
    always_comb begin
        w_wold    = '0;
        w_wmapped = 1'b0;
        if (csr_waddr == ADDR_INHIBIT) begin
            w_wold    = w_inh_view;
            w_wmapped = 1'b1;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (csr_waddr == addr_f(ADDR_MLO, i)) begin
                w_wold    = cnt_q[i][31:0];
                w_wmapped = 1'b1;
            end
            if (csr_waddr == addr_f(ADDR_MHI, i)) begin
                w_wold    = 32'(cnt_q[i][CNT_WIDTH-1:32]);
                w_wmapped = 1'b1;
            end
        end
    end

    always_comb begin
        w_wnew = csr_wdata;
        case (csr_op)
            OP_WRITE: w_wnew = csr_wdata;
            OP_SET:   w_wnew = w_wold | csr_wdata;
            OP_CLEAR: w_wnew = w_wold & ~csr_wdata;
            default:  w_wnew = w_wold;
        endcase
    end

    assign w_we           = (csr_op != OP_NONE) && w_wmapped;
    assign csr_wr_illegal = (csr_op != OP_NONE) && !w_wmapped;

    always_comb begin
        inh_d = inh_q;
        if (w_we && csr_waddr == ADDR_INHIBIT) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                inh_d[i] = w_wnew[off_f(i)];
            end
        end
    end

    // A lo write suppresses the increment; a hi write lets lo count but drops its carry.
    always_comb begin
        w_en   = '0;
        w_wrap = '0;
        ovf_d  = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            w_en[i]  = !inh_q[i] && (i == 0 || evt_i[i]);
            if (w_we && csr_waddr == addr_f(ADDR_MLO, i)) begin
                cnt_d[i][31:0] = w_wnew;
            end else if (w_we && csr_waddr == addr_f(ADDR_MHI, i)) begin
                cnt_d[i][CNT_WIDTH-1:32] = w_wnew[HI_W-1:0];
                cnt_d[i][31:0]           = cnt_q[i][31:0] + 32'(w_en[i]);
            end else if (w_en[i]) begin
                cnt_d[i]  = cnt_q[i] + CNT_WIDTH'(1);
                w_wrap[i] = &cnt_q[i];
            end
            ovf_d[i] = w_wrap[i] && !inh_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
            end
            inh_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inh_q <= inh_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_counter_bank
// Description : Self-checking bench for csr_counter_bank: directed table,
//               hand-written corner sequences and a randomized model phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_counter_bank;

    localparam int N = 4;
    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   csr_raddr;
    logic [31:0]   csr_rdata;
    logic          csr_rd_illegal;
    logic [1:0]    csr_op;
    logic [11:0]   csr_waddr;
    logic [31:0]   csr_wdata;
    logic          csr_wr_illegal;
    logic [N-1:0]  evt_i;
    logic [N-1:0]  ovf_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    csr_counter_bank #(.NUM_COUNTERS(N), .CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_rd_illegal(csr_rd_illegal),
        .csr_op(csr_op), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_wr_illegal(csr_wr_illegal), .evt_i(evt_i), .ovf_o(ovf_o)
    );

    // ---------------- reference model ----------------
    longint unsigned m_cnt [N];
    bit [31:0]       m_inh;
    bit [N-1:0]      m_ovf;

    function automatic int off(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : i + 1);
    endfunction

    function automatic longint unsigned cmask();
        return (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << W) - 64'd1);
    endfunction

    function automatic bit [31:0] impl_mask();
        bit [31:0] m = '0;
        for (int i = 0; i < N; i++) m[off(i)] = 1'b1;
        return m;
    endfunction

    function automatic int ctr_of(input int o);
        for (int i = 0; i < N; i++) if (off(i) == o) return i;
        return -1;
    endfunction

    task automatic m_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
        int c;
        logic [11:0] base;
        d = '0; ill = 1'b1;
        base = a & 12'hFE0;
        c = ctr_of(int'(a[4:0]));
        if (a == 12'h320) begin
            d = m_inh; ill = 1'b0;
        end else if (c >= 0 && (base == 12'hB00 || base == 12'hC00)) begin
            d = m_cnt[c][31:0]; ill = 1'b0;
        end else if (c >= 0 && (base == 12'hB80 || base == 12'hC80)) begin
            d = 32'(m_cnt[c] >> 32); ill = 1'b0;
        end
    endtask

    function automatic bit m_writable(input logic [11:0] a);
        int c;
        c = ctr_of(int'(a[4:0]));
        return (a == 12'h320) ||
               (c >= 0 && ((a & 12'hFE0) == 12'hB00 || (a & 12'hFE0) == 12'hB80));
    endfunction

    task automatic m_step(input logic r, input logic [1:0] op, input logic [11:0] wa,
                          input logic [31:0] wd, input logic [N-1:0] ev);
        logic [31:0] old, nv;
        logic        rill;
        bit          legal, wrapped;
        bit [31:0]   inh_next;
        longint unsigned nc [N];
        longint unsigned en;
        bit [N-1:0]  ovf_next;
        if (r) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_inh = '0; m_ovf = '0;
            return;
        end
        m_read(wa, old, rill);
        legal = (op != 2'b00) && m_writable(wa);
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        inh_next = (legal && wa == 12'h320) ? (nv & impl_mask()) : m_inh;
        for (int i = 0; i < N; i++) begin
            en = (!m_inh[off(i)] && (i == 0 || ev[i])) ? 1 : 0;
            wrapped = 1'b0;
            nc[i] = m_cnt[i];
            if (legal && wa == 12'hB00 + 12'(off(i)))
                nc[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(nv);
            else if (legal && wa == 12'hB80 + 12'(off(i)))
                nc[i] = ((64'(nv) << 32) | ((m_cnt[i] + en) & 64'hFFFF_FFFF)) & cmask();
            else if (en != 0) begin
                wrapped = (m_cnt[i] == cmask());
                nc[i] = (m_cnt[i] + 1) & cmask();
            end
            ovf_next[i] = wrapped && !inh_next[off(i)];
        end
        for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
        m_inh = inh_next;
        m_ovf = ovf_next;
    endtask

    // ---------------- drive / check helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] op, input logic [11:0] wa,
                         input logic [31:0] wd, input logic [11:0] ra, input logic [N-1:0] ev);
        rst = r; csr_op = op; csr_waddr = wa; csr_wdata = wd; csr_raddr = ra; evt_i = ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step(rst, csr_op, csr_waddr, csr_wdata, evt_i);
        @(negedge clk);
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] ra, input logic [31:0] exp,
                          input logic [N-1:0] exp_ovf);
        drive(1'b0, 2'b00, 12'h000, 32'h0, ra, '0);
        chk({nm, "_rdata"}, csr_rdata, exp);
        chk({nm, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
        tick();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [N-1:0] ev;
        logic [31:0] rd;
        logic        rill;
        logic        will;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] op, input logic [11:0] wa, input logic [31:0] wd,
                       input logic [11:0] ra, input logic [N-1:0] ev, input logic [31:0] rd,
                       input logic rill, input logic will);
        vec_t v;
        v.op = op; v.wa = wa; v.wd = wd; v.ra = ra; v.ev = ev;
        v.rd = rd; v.rill = rill; v.will = will;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_ill;
        logic [11:0] pool [13];

        // Reset held 3 cycles with all events active.
        drive(1'b1, 2'b00, 12'h000, 32'h0, 12'hB00, '1);
        repeat (3) tick();
        foreach (pool[k]) pool[k] = 12'h000;
        pool[0] = 12'hB00; pool[1] = 12'hB80; pool[2] = 12'hB02; pool[3] = 12'hB82;
        pool[4] = 12'hB03; pool[5] = 12'hB83; pool[6] = 12'hB04; pool[7] = 12'hB84;
        pool[8] = 12'h320;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 2'b00, 12'h000, 32'h0, pool[k], '1);
            chk("reset_rdata", csr_rdata, 32'h0);
            chk("reset_ovf", 32'(ovf_o), 32'h0);
            tick();
        end

        // Directed table; mcycle starts at 0 on the first row.
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd0,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd1,   0, 0);
        add(2'd1, 12'hB03, 32'h0F0,      12'hB03, 4'h0, 32'h0,   0, 0);
        add(2'd2, 12'hB03, 32'h00F,      12'hB03, 4'h0, 32'hF0,  0, 0);
        add(2'd3, 12'hB03, 32'h0F0,      12'hB03, 4'h0, 32'hFF,  0, 0);
        add(2'd1, 12'hC00, 32'h1234,     12'hB03, 4'h0, 32'h0F,  0, 1);
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd6,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hC00, 4'h0, 32'd7,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hC80, 4'h0, 32'd0,   0, 0);
        add(2'd1, 12'h320, 32'h1,        12'hB00, 4'h0, 32'd9,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd10,  0, 0);
        add(2'd0, 12'h000, 32'h0,        12'h320, 4'h0, 32'h1,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'h321, 4'h0, 32'h0,   1, 0);
        add(2'd0, 12'h000, 32'h0,        12'h301, 4'h0, 32'h0,   1, 0);
        add(2'd1, 12'h320, 32'h0,        12'hB00, 4'h0, 32'd10,  0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd10,  0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd11,  0, 0);
        add(2'd1, 12'h320, 32'hFFFFFFFF, 12'h320, 4'h0, 32'h0,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'h320, 4'h0, 32'h1D,  0, 0);
        add(2'd1, 12'hB00, 32'h5,        12'hB00, 4'h0, 32'd13,  0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd5,   0, 0);
        add(2'd1, 12'h320, 32'h0,        12'hB00, 4'h0, 32'd5,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB00, 4'h0, 32'd5,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB02, 4'h2, 32'd0,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hB02, 4'h0, 32'd1,   0, 0);
        add(2'd0, 12'h000, 32'h0,        12'hC02, 4'h1, 32'd1,   0, 0);
        add(2'd2, 12'hB01, 32'h1,        12'hB01, 4'h0, 32'h0,   1, 1);
        add(2'd3, 12'hC83, 32'h0,        12'h320, 4'h0, 32'h0,   0, 1);
        foreach (tbl[k]) begin
            drive(1'b0, tbl[k].op, tbl[k].wa, tbl[k].wd, tbl[k].ra, tbl[k].ev);
            chk($sformatf("tbl%0d_rdata", k), csr_rdata, tbl[k].rd);
            chk($sformatf("tbl%0d_rd_ill", k), 32'(csr_rd_illegal), 32'(tbl[k].rill));
            chk($sformatf("tbl%0d_wr_ill", k), 32'(csr_wr_illegal), 32'(tbl[k].will));
            chk($sformatf("tbl%0d_ovf", k), 32'(ovf_o), 32'h0);
            tick();
        end

        // Carry from lo into hi of mcycle.
        drive(1'b0, 2'b01, 12'hB00, 32'hFFFFFFFF, 12'hB00, '0); tick();
        rd_chk("carry_lo_full", 12'hB00, 32'hFFFFFFFF, '0);
        rd_chk("carry_lo_zero", 12'hB00, 32'h0, '0);
        rd_chk("carry_hi", 12'hB80, 32'h1, '0);

        // Full wrap of counter 2 (hpmcounter3).
        drive(1'b0, 2'b01, 12'hB83, 32'hFFFFFFFF, 12'hB83, '0); tick();
        drive(1'b0, 2'b01, 12'hB03, 32'hFFFFFFFF, 12'hB03, '0); tick();
        drive(1'b0, 2'b00, 12'h000, 32'h0, 12'hB83, 4'b0100);
        chk("wrap_hi_full", csr_rdata, 32'hFFFFFFFF);
        chk("wrap_ovf_pre", 32'(ovf_o), 32'h0);
        tick();
        rd_chk("wrap_lo", 12'hB03, 32'h0, 4'b0100);
        rd_chk("wrap_hi", 12'hB83, 32'h0, 4'b0000);

        // hi write while lo is about to carry: carry is lost.
        drive(1'b0, 2'b01, 12'hB00, 32'hFFFFFFFF, 12'hB00, '0); tick();
        drive(1'b0, 2'b01, 12'hB80, 32'h0000ABCD, 12'hB00, '0);
        chk("coll_lo_pre", csr_rdata, 32'hFFFFFFFF);
        tick();
        rd_chk("coll_hi", 12'hB80, 32'h0000ABCD, '0);
        rd_chk("coll_lo", 12'hB00, 32'h1, '0);

        // Reset wins over a concurrent write.
        drive(1'b1, 2'b01, 12'hB00, 32'h1234, 12'hB00, '1); tick();
        rd_chk("rstmid_lo", 12'hB00, 32'h0, '0);
        rd_chk("rstmid_hi", 12'hB80, 32'h0, '0);
        rd_chk("rstmid_c2", 12'hB83, 32'h0, '0);

        // Randomized phase against the reference model.
        drive(1'b1, 2'b00, 12'h000, 32'h0, 12'h000, '0); tick();
        pool[9] = 12'hC00; pool[10] = 12'hC83; pool[11] = 12'hB01; pool[12] = 12'h000;
        for (int n = 0; n < 800; n++) begin
            logic        r;
            logic [1:0]  op;
            logic [11:0] wa, ra;
            logic [31:0] wd;
            r  = ($urandom_range(0, 99) == 0);
            op = ($urandom_range(0, 2) == 0) ? 2'(op_rand()) : 2'b00;
            wa = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 12)];
            ra = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 12)];
            case ($urandom_range(0, 3))
                0:       wd = 32'hFFFFFFFF;
                1:       wd = 32'hFFFFFFFE;
                2:       wd = 32'h0;
                default: wd = $urandom;
            endcase
            drive(r, op, wa, wd, ra, N'($urandom));
            m_read(ra, exp_d, exp_ill);
            chk("rnd_rdata", csr_rdata, exp_d);
            chk("rnd_rd_ill", 32'(csr_rd_illegal), 32'(exp_ill));
            chk("rnd_wr_ill", 32'(csr_wr_illegal), 32'((op != 2'b00) && !m_writable(wa)));
            chk("rnd_ovf", 32'(ovf_o), 32'(m_ovf));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic int op_rand();
        return $urandom_range(1, 3);
    endfunction

endmodule
`default_nettype wire
